// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control sequencer.
package stopwatch_pkg;
    typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSE, FULL} sw_state_t;

    localparam logic [15:0] MAX_BCD_DEF     = 16'h5999;
    localparam int          BLINK_TICKS_DEF = 50;
endpackage

// File: rtl/edge_det.sv
// Rising-edge detector on a debounced key level. The history register resets
// high so that a key held through reset does not look like a fresh press.
module edge_det (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) d_q <= 1'b1;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: gates ticks to the counter chain, clears it,
// freezes the display for laps, saturates at MAX_BCD and drives the dp status.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter logic [15:0] MAX_BCD     = MAX_BCD_DEF,
    parameter int          BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        key_ss,
    input  logic        key_lr,
    input  logic        tick,
    input  logic [15:0] time_bcd,
    output logic        cnt_tick,
    output logic        cnt_clr,
    output logic [15:0] disp_bcd,
    output logic        dp,
    output logic        running
);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    sw_state_t      state, state_nxt;
    logic           ss_e, lr_raw, lr_e;
    logic           at_max, full_hit;
    logic           lap_load, clr_nxt, dp_nxt;
    logic [BW-1:0]  blink_cnt, blink_nxt;
    logic [15:0]    lap_reg;

    edge_det u_ss (.clk(clk), .nrst(nrst), .d(key_ss), .rise(ss_e));
    edge_det u_lr (.clk(clk), .nrst(nrst), .d(key_lr), .rise(lr_raw));

    // Start/stop wins a simultaneous press; the lap/reset edge is dropped.
    assign lr_e     = lr_raw & ~ss_e;
    assign at_max   = (time_bcd == MAX_BCD);
    assign full_hit = tick & at_max;

    always_comb begin
        state_nxt = state;
        lap_load  = 1'b0;
        clr_nxt   = 1'b0;
        case (state)
            IDLE:  if (ss_e) state_nxt = RUN;
            RUN: begin
                if (ss_e)          state_nxt = PAUSE;
                else if (lr_e)     begin state_nxt = LAP; lap_load = 1'b1; end
                else if (full_hit) state_nxt = FULL;
            end
            LAP: begin
                if (ss_e)          state_nxt = PAUSE;
                else if (lr_e)     state_nxt = RUN;
                else if (full_hit) state_nxt = FULL;
            end
            PAUSE: begin
                if (ss_e)      state_nxt = RUN;
                else if (lr_e) begin state_nxt = IDLE; clr_nxt = 1'b1; end
            end
            FULL:  if (lr_e) begin state_nxt = IDLE; clr_nxt = 1'b1; end
            default: state_nxt = IDLE;
        endcase
    end

    // Blink restarts lit on every entry into LAP or FULL, including LAP->FULL.
    always_comb begin
        blink_nxt = '0;
        dp_nxt    = 1'b0;
        if (state_nxt == LAP || state_nxt == FULL) begin
            if (state_nxt != state) begin
                dp_nxt = 1'b1;
            end else begin
                dp_nxt    = dp;
                blink_nxt = blink_cnt;
                if (tick) begin
                    if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                        blink_nxt = '0;
                        dp_nxt    = ~dp;
                    end else begin
                        blink_nxt = blink_cnt + BW'(1);
                    end
                end
            end
        end else begin
            dp_nxt = (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            lap_reg   <= '0;
            cnt_clr   <= 1'b0;
            dp        <= 1'b0;
            blink_cnt <= '0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_clr   <= clr_nxt;
            dp        <= dp_nxt;
            blink_cnt <= blink_nxt;
            running   <= (state_nxt == RUN) || (state_nxt == LAP);
            if (lap_load) lap_reg <= time_bcd;
        end
    end

    // Gating on the registered state keeps the counters from wrapping past MAX_BCD.
    assign cnt_tick = tick & ((state == RUN) || (state == LAP)) & ~at_max;
    assign disp_bcd = (state == LAP) ? lap_reg : time_bcd;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and a
// randomized run against a rule-level reference model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam logic [15:0] MAXV = 16'h5999;
    localparam int          BT   = 50;

    logic        clk = 1'b0, nrst = 1'b0;
    logic        key_ss = 1'b0, key_lr = 1'b0, tick = 1'b0;
    logic [15:0] time_bcd = 16'h0000;
    logic        cnt_tick, cnt_clr, dp, running;
    logic [15:0] disp_bcd;

    stopwatch_ctrl #(.MAX_BCD(MAXV), .BLINK_TICKS(BT)) dut (
        .clk(clk), .nrst(nrst), .key_ss(key_ss), .key_lr(key_lr), .tick(tick),
        .time_bcd(time_bcd), .cnt_tick(cnt_tick), .cnt_clr(cnt_clr),
        .disp_bcd(disp_bcd), .dp(dp), .running(running)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Inputs change 1ns after the edge; caller checks after the falling edge.
    task automatic cyc(input logic ss, input logic lr, input logic tk, input logic [15:0] t);
        @(posedge clk);
        #1;
        key_ss = ss; key_lr = lr; tick = tk; time_bcd = t;
        @(negedge clk);
    endtask

    typedef struct {
        logic        ss, lr, tk;
        logic [15:0] t;
        logic        e_tick, e_clr, e_run, e_dp;
        logic [15:0] e_disp;
    } vec_t;

    vec_t v[22];

    function automatic vec_t mk(logic ss, logic lr, logic tk, logic [15:0] t,
                                logic et, logic ec, logic er, logic ed, logic [15:0] edisp);
        vec_t r;
        r.ss = ss; r.lr = lr; r.tk = tk; r.t = t;
        r.e_tick = et; r.e_clr = ec; r.e_run = er; r.e_dp = ed; r.e_disp = edisp;
        return r;
    endfunction

    // Reference model: stopwatch rules expressed as modes plus "ticks since entry".
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3, M_FULL = 4;
    int          m_mode, m_blink;
    logic        m_ssq, m_lrq, m_clr;
    logic [15:0] m_lap;

    task automatic model_reset();
        m_mode = M_IDLE; m_blink = 0; m_ssq = 1'b1; m_lrq = 1'b1; m_clr = 1'b0; m_lap = '0;
    endtask

    task automatic model_update();
        bit sse, lre, fh;
        int nm;
        sse = key_ss && !m_ssq;
        lre = key_lr && !m_lrq && !sse;
        fh  = tick && (time_bcd == MAXV);
        nm = m_mode; m_clr = 1'b0;
        case (m_mode)
            M_IDLE:  if (sse) nm = M_RUN;
            M_RUN:   if (sse) nm = M_PAUSE;
                     else if (lre) begin nm = M_LAP; m_lap = time_bcd; end
                     else if (fh) nm = M_FULL;
            M_LAP:   if (sse) nm = M_PAUSE; else if (lre) nm = M_RUN; else if (fh) nm = M_FULL;
            M_PAUSE: if (sse) nm = M_RUN; else if (lre) begin nm = M_IDLE; m_clr = 1'b1; end
            M_FULL:  if (lre) begin nm = M_IDLE; m_clr = 1'b1; end
            default: nm = M_IDLE;
        endcase
        if (nm != m_mode) m_blink = 0;
        else if (tick)    m_blink++;
        m_mode = nm; m_ssq = key_ss; m_lrq = key_lr;
    endtask

    task automatic model_check();
        logic act_mode, e_tk, e_dp;
        act_mode = (m_mode == M_RUN) || (m_mode == M_LAP);
        e_tk = tick && act_mode && (time_bcd != MAXV);
        if (m_mode == M_RUN) e_dp = 1'b1;
        else if (m_mode == M_LAP || m_mode == M_FULL) e_dp = ((m_blink / BT) % 2) == 0;
        else e_dp = 1'b0;
        chk("rnd_tick", 16'(cnt_tick), 16'(e_tk));
        chk("rnd_clr",  16'(cnt_clr),  16'(m_clr));
        chk("rnd_run",  16'(running),  16'(act_mode));
        chk("rnd_dp",   16'(dp),       16'(e_dp));
        chk("rnd_disp", disp_bcd, (m_mode == M_LAP) ? m_lap : time_bcd);
    endtask

    initial begin
        // Reset with start/stop held and a tick present.
        key_ss = 1'b1; tick = 1'b1; time_bcd = 16'h0042;
        @(negedge clk); @(negedge clk);
        chk("rst_tick", 16'(cnt_tick), 16'h0);
        chk("rst_clr",  16'(cnt_clr),  16'h0);
        chk("rst_dp",   16'(dp),       16'h0);
        chk("rst_run",  16'(running),  16'h0);
        chk("rst_disp", disp_bcd, 16'h0042);
        tick = 1'b0; time_bcd = 16'h0000;
        nrst = 1'b1;

        v[0]  = mk(1,0,0,16'h0000, 0,0,0,0,16'h0000);
        v[1]  = mk(0,0,0,16'h0000, 0,0,0,0,16'h0000);
        v[2]  = mk(1,0,1,16'h0000, 0,0,0,0,16'h0000);
        v[3]  = mk(1,0,1,16'h0000, 1,0,1,1,16'h0000);
        v[4]  = mk(0,0,0,16'h0001, 0,0,1,1,16'h0001);
        v[5]  = mk(0,0,1,16'h0001, 1,0,1,1,16'h0001);
        v[6]  = mk(0,0,1,16'h0002, 1,0,1,1,16'h0002);
        v[7]  = mk(0,1,0,16'h0123, 0,0,1,1,16'h0123);
        v[8]  = mk(0,1,1,16'h0124, 1,0,1,1,16'h0123);
        v[9]  = mk(0,0,1,16'h0150, 1,0,1,1,16'h0123);
        v[10] = mk(0,1,0,16'h0150, 0,0,1,1,16'h0123);
        v[11] = mk(0,0,0,16'h0150, 0,0,1,1,16'h0150);
        v[12] = mk(1,0,1,16'h0151, 1,0,1,1,16'h0151);
        v[13] = mk(0,0,1,16'h0152, 0,0,0,0,16'h0152);
        v[14] = mk(0,1,0,16'h0152, 0,0,0,0,16'h0152);
        v[15] = mk(0,0,0,16'h0152, 0,1,0,0,16'h0152);
        v[16] = mk(0,0,0,16'h0152, 0,0,0,0,16'h0152);
        v[17] = mk(1,1,0,16'h0152, 0,0,0,0,16'h0152);
        v[18] = mk(0,0,0,16'h0200, 0,0,1,1,16'h0200);
        v[19] = mk(1,1,0,16'h0300, 0,0,1,1,16'h0300);
        v[20] = mk(0,0,0,16'h0301, 0,0,0,0,16'h0301);
        v[21] = mk(0,0,1,16'h0301, 0,0,0,0,16'h0301);

        for (int i = 0; i < 22; i++) begin
            cyc(v[i].ss, v[i].lr, v[i].tk, v[i].t);
            chk($sformatf("vec%0d_tick", i), 16'(cnt_tick), 16'(v[i].e_tick));
            chk($sformatf("vec%0d_clr",  i), 16'(cnt_clr),  16'(v[i].e_clr));
            chk($sformatf("vec%0d_run",  i), 16'(running),  16'(v[i].e_run));
            chk($sformatf("vec%0d_dp",   i), 16'(dp),       16'(v[i].e_dp));
            chk($sformatf("vec%0d_disp", i), disp_bcd, v[i].e_disp);
        end
        chk("simul_no_lap_load", dut.lap_reg, 16'h0123);

        // Saturation and FULL blink, starting from PAUSE.
        cyc(1,0,0,16'h1000);
        cyc(0,0,1,MAXV);
        chk("max_tick_gated", 16'(cnt_tick), 16'h0);
        chk("max_run",        16'(running),  16'h1);
        for (int k = 0; k < 100; k++) begin
            cyc(0,0,1,MAXV);
            chk($sformatf("full_dp_k%0d", k), 16'(dp), (k < BT) ? 16'h1 : 16'h0);
            if (k == 0) begin
                chk("full_run",  16'(running),  16'h0);
                chk("full_tick", 16'(cnt_tick), 16'h0);
            end
        end
        cyc(0,0,0,MAXV);
        chk("full_dp_100", 16'(dp), 16'h1);
        cyc(1,0,1,16'h1234);
        cyc(0,0,0,16'h1234);
        chk("full_ss_ignored_dp",  16'(dp),      16'h1);
        chk("full_ss_ignored_run", 16'(running), 16'h0);
        cyc(0,1,0,16'h1234);
        chk("full_lr_clr0", 16'(cnt_clr), 16'h0);
        cyc(0,0,0,16'h1234);
        chk("full_lr_clr1", 16'(cnt_clr), 16'h1);
        chk("full_lr_dp",   16'(dp),      16'h0);
        chk("full_lr_run",  16'(running), 16'h0);
        cyc(0,0,0,16'h1234);
        chk("full_lr_clr_once", 16'(cnt_clr), 16'h0);

        // Asynchronous reset while in LAP.
        cyc(1,0,0,16'h0700);
        cyc(0,1,0,16'h0777);
        cyc(0,0,0,16'h0780);
        chk("lap_disp", disp_bcd, 16'h0777);
        chk("lap_run",  16'(running), 16'h1);
        #1 nrst = 1'b0; tick = 1'b1;
        #1;
        chk("arst_disp",  disp_bcd, 16'h0780);
        chk("arst_dp",    16'(dp),       16'h0);
        chk("arst_run",   16'(running),  16'h0);
        chk("arst_tick",  16'(cnt_tick), 16'h0);
        chk("arst_clr",   16'(cnt_clr),  16'h0);
        chk("arst_lap",   dut.lap_reg,   16'h0000);
        chk("arst_state", 16'(dut.state), 16'(IDLE));
        key_ss = 1'b0; key_lr = 1'b0; tick = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        model_reset();

        // Randomized run against the reference model.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            model_update();
            #1;
            if ($urandom_range(0, 9) == 0)  key_ss = ~key_ss;
            if ($urandom_range(0, 15) == 0) key_lr = ~key_lr;
            tick     = ($urandom_range(0, 2) == 0);
            time_bcd = ($urandom_range(0, 5) == 0) ? MAXV : 16'($urandom_range(0, 16'h5998));
            @(negedge clk);
            model_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
